// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch pipeline.
// Fetch FSM states and the buffered fetch entry live here.
package riscv_pkg;

    localparam int              XLEN   = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch buffer: push/pop/flush with occupancy count.
// A push into a full buffer is accepted when a pop happens on the same edge.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  wdata,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage producer: PC register, imem request issue, redirect flush, fetch buffer.
// Define FETCH_MISALIGN_CHECK_EN to add the sticky fetch_misalign output.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] instrCode,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign
`endif
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          SW      = $clog2(4 * FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   stale;
    logic [SW-1:0]   stale_next;
    logic            redirect_take;
    logic            gnt_fire;
    logic            rsp_stale;
    logic            rsp_live;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic            halted;
    logic            fifo_empty;
    logic            fifo_full_unused;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else if (redirect_take) begin
            misalign <= |redirect_pc[1:0];
        end
    end

    assign fetch_misalign = misalign;
    assign halted         = misalign;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign halted          = 1'b0;
`endif

    assign redirect_take = redirect_valid && (state != BOOT);
    assign gnt_fire      = imem_req && imem_gnt;

    // A response with nothing in flight is a leftover from before reset.
    assign rsp_stale = imem_rvalid && (stale != '0);
    assign rsp_live  = imem_rvalid && (stale == '0) && (outstanding != '0);
    assign rsp_fire  = rsp_stale || rsp_live;

    assign fetch_valid = !fifo_empty;
    assign pop         = fetch_valid && id_ready && !redirect_take;
    assign push        = rsp_live && !redirect_take;

    // A slot freed by this cycle's pop can be refilled by this cycle's grant.
    assign imem_req  = (state != BOOT) && !halted &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}
                         - {{CW{1'b0}}, pop}) < DEPTH_W);
    assign imem_addr = fetch_pc;

    assign push_entry = '{instr: imem_rdata, pc: resp_pc};

    always_comb begin
        stale_next = stale;
        if (redirect_take) begin
            stale_next = stale + SW'(outstanding) + SW'(gnt_fire)
                       - SW'(rsp_fire);
        end else if (rsp_stale) begin
            stale_next = stale - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            stale <= stale_next;
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect_take && stale_next != '0) state <= FLUSH;
                FLUSH:   if (stale_next == '0) state <= RUN;
                default: state <= BOOT;
            endcase
            if (redirect_take) begin
                fetch_pc    <= target;
                resp_pc     <= target;
                outstanding <= '0;
            end else begin
                if (gnt_fire) begin
                    fetch_pc <= fetch_pc + PC_INC;
                end
                if (rsp_live) begin
                    resp_pc <= resp_pc + PC_INC;
                end
                outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_live);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (redirect_take),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full_unused),
        .empty (fifo_empty)
    );

    assign instrCode = fetch_valid ? head.instr : '0;
    assign PC        = fetch_valid ? head.pc : '0;
    assign PC_4      = fetch_valid ? head.pc + PC_INC : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random imem/stall/redirect traffic against a stream model.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        fetch_valid;
    logic [31:0] instrCode;
    logic [31:0] PC;
    logic [31:0] PC_4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .fetch_valid    (fetch_valid),
        .instrCode      (instrCode),
        .PC             (PC),
        .PC_4           (PC_4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc      = 0;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          consumed = 0;
    int          gnt_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        s_valid;
    logic        s_req;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] last_pc;
    logic [31:0] last_pc4;
    logic        hold;
    logic        was_redir;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        got;

    // Memory contents are a fixed hash of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, fetch_valid}, 32'd0);
        check({tag, "_instr"}, instrCode, 32'd0);
        check({tag, "_pc"}, PC, 32'd0);
        check({tag, "_pc4"}, PC_4, 32'd0);
    endtask

    // One clock cycle: drive at negedge, sample #1 later, update the model.
    task automatic step(input logic rdy, input logic redir,
                        input logic [31:0] tgt);
        logic g;
        g = ($urandom_range(99) < gnt_pct);
        imem_gnt = g;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = imem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        s_valid = fetch_valid;
        s_req   = imem_req;
        s_pc    = PC;
        s_instr = instrCode;
        if (was_redir) check("valid_after_redirect", {31'b0, s_valid}, 32'd0);
        if (hold) begin
            check("stall_valid", {31'b0, s_valid}, 32'd1);
            check("stall_pc", s_pc, hold_pc);
            check("stall_instr", s_instr, hold_instr);
        end
        if (s_valid) begin
            check("pc4", PC_4, s_pc + 32'd4);
            check("instr", s_instr, imem_word(s_pc));
        end
        if (s_valid && rdy && !redir) begin
            check("stream_pc", s_pc, exp_pc);
            exp_pc   = exp_pc + 32'd4;
            last_pc  = s_pc;
            last_pc4 = PC_4;
            consumed++;
        end
        if (s_req && g) begin
            if (!redir) begin
                check("req_addr", imem_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            pend.push_back('{addr: imem_addr,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
        if (redir) begin
            exp_pc   = {tgt[31:2], 2'b00};
            exp_addr = {tgt[31:2], 2'b00};
        end
        hold       = s_valid && !rdy && !redir;
        hold_pc    = s_pc;
        hold_instr = s_instr;
        was_redir  = redir;
        @(negedge clk);
        cyc++;
    endtask

    task automatic consume_next(input string tag, input logic [31:0] want,
                                input int budget);
        int c0;
        c0  = consumed;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step(1'b1, 1'b0, 32'h0);
            got = (consumed != c0);
        end
        check({tag, "_seen"}, {31'b0, got}, 32'd1);
        if (got) check(tag, last_pc, want);
    endtask

    // Release at a negedge; that cycle is BOOT, optionally with a late response.
    task automatic release_reset(input logic late_rsp);
        rst         = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = late_rsp;
        imem_rdata  = 32'hDEAD_BEEF;
        id_ready    = 1'b1;
        #1;
        check("boot_no_req", {31'b0, imem_req}, 32'd0);
        exp_pc    = RESET_PC;
        exp_addr  = RESET_PC;
        hold      = 1'b0;
        was_redir = 1'b0;
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic        r;
        logic [31:0] t;
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        hold           = 1'b0;
        was_redir      = 1'b0;
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        release_reset(1'b0);

        step(1'b1, 1'b0, 32'h0);
        check("first_req", {31'b0, s_req}, 32'd1);
        check("lat_n", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("lat_n1", {31'b0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check("lat_n2", {31'b0, s_valid}, 32'd1);
        check("first_pc", s_pc, RESET_PC);
        c0 = consumed;
        repeat (8) step(1'b1, 1'b0, 32'h0);
        check("throughput", 32'(consumed - c0), 32'd8);

        repeat (5) step(1'b0, 1'b0, 32'h0);
        check("stall_req_drop", {31'b0, s_req}, 32'd0);
        c0 = consumed;
        repeat (6) step(1'b1, 1'b0, 32'h0);
        check("resume_rate", 32'(consumed - c0), 32'd6);

        step(1'b1, 1'b1, 32'h200);
        check("redir_had_valid", {31'b0, s_valid}, 32'd1);
        consume_next("redir_same_cycle", 32'h200, 10);

        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++) step(1'b1, 1'b0, 32'h0);
        check("two_outstanding", 32'(pend.size()), 32'd2);
        step(1'b1, 1'b1, 32'h100);
        consume_next("redir_two_out", 32'h100, 30);

        lat_min = 1;
        lat_max = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        consume_next("wrap_a", 32'hFFFF_FFF8, 10);
        consume_next("wrap_b", 32'hFFFF_FFFC, 10);
        check("wrap_pc4", last_pc4, 32'h0);
        consume_next("wrap_c", 32'h0, 10);

        lat_min = 3;
        lat_max = 3;
        repeat (4) step(1'b1, 1'b0, 32'h0);
        check("inflight", {31'b0, pend.size() > 0}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        pend.delete();
        imem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc = cyc + 2;
        lat_min = 1;
        lat_max = 1;
        release_reset(1'b1);
        consume_next("post_reset_pc", RESET_PC, 10);

`ifdef FETCH_MISALIGN_CHECK_EN
        step(1'b1, 1'b1, 32'h102);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            check("misalign_flag", {31'b0, fetch_misalign}, 32'd1);
            check("misalign_no_req", {31'b0, s_req}, 32'd0);
            check("misalign_no_valid", {31'b0, s_valid}, 32'd0);
        end
        step(1'b1, 1'b1, 32'h300);
        step(1'b1, 1'b0, 32'h0);
        check("misalign_clear", {31'b0, fetch_misalign}, 32'd0);
        consume_next("misalign_recover", 32'h300, 10);
`endif

        gnt_pct = 70;
        lat_min = 1;
        lat_max = 3;
        c0 = consumed;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(99) < 4);
            t = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0
                                         : ($urandom & 32'h0000_3FFC);
            step($urandom_range(99) < 70, r, t);
        end
        check("random_progress", {31'b0, (consumed - c0) > 150}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
